wbu_nb: RTL and testbench

Non-blocking, parametrised write-back unit that sits between the memory stage and the register file. Accepted memory-stage instructions enter an in-order retirement queue of DEPTH entries. Loads retire only after their data-memory response arrives, so the memory stage can issue further accesses while earlier loads are outstanding. Responses are matched in order, sign/zero-extended, and written back in program order. The retired instruction is reported on the `wbu_*` trace outputs.

---
 rtl/cpu_core_pkg.sv | 36 +++
 rtl/wbu_load_align.sv | 45 ++++
 rtl/wbu_nb.sv | 168 ++++++++++++++++
 tb/tb_wbu_nb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared core definitions.
// Contents used by the write-back unit:
//   NOP_INSTRUCT  canonical "addi x0,x0,0", the idle trace value
//   F3_*          load-size encodings of func3
//   wbu_kind_e    retirement-queue entry kind (ALU / LOAD / STORE)
//   wbu_entry_t   one retirement-queue entry; pc/data are sized for the
//                 widest XLEN (64) and narrowed by the user
package cpu_core_pkg;

  localparam logic [31:0] NOP_INSTRUCT = 32'h0000_0013;
  localparam int          WBU_XLEN_MAX = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    ALU   = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } wbu_kind_e;

  typedef struct packed {
    logic [WBU_XLEN_MAX-1:0] pc;
    logic [31:0]             instruct;
    logic [4:0]              rd;
    logic [WBU_XLEN_MAX-1:0] data;
    wbu_kind_e               kind;
    logic [2:0]              offset;
    logic [2:0]              func3;
  } wbu_entry_t;

endpackage

// File: rtl/wbu_load_align.sv
// wbu_load_align: combinational load-data alignment and extension.
// Ports:
//   raw_i     XLEN      raw data-memory response word
//   offset_i  OFF_W     byte offset of the access within the word
//   func3_i   3         load size/sign selector
//   data_o    XLEN      value to write to the register file
module wbu_load_align
  import cpu_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  raw_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [2:0]       func3_i,
  output logic [XLEN-1:0]  data_o
);

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] sh,
                                              input logic [2:0]      f3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = signed'(sh[7:0]);
    h = signed'(sh[15:0]);
    w = signed'(sh[31:0]);
    case (f3)
      F3_LB:   extend = XLEN'(b);
      F3_LH:   extend = XLEN'(h);
      F3_LBU:  extend = XLEN'(sh[7:0]);
      F3_LHU:  extend = XLEN'(sh[15:0]);
      // Only a 64-bit core has a zero-extending word load.
      F3_LWU:  extend = (XLEN > 32) ? XLEN'(sh[31:0]) : XLEN'(w);
      default: extend = XLEN'(w);
    endcase
  endfunction

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = raw_i >> {offset_i, 3'b000};
    data_o  = extend(shifted, func3_i);
  end

endmodule

// File: rtl/wbu_nb.sv
// wbu_nb: non-blocking write-back unit with an in-order retirement queue.
// Memory-stage instructions are queued; loads wait for their in-order
// data-memory response, everything retires in program order.
// Ports:
//   clock_i, nreset_i                 clock, async active-low reset
//   mem_*_i, is_mem_op_i, mem_op_type_i  incoming memory-stage instruction
//   mem_stall_o                       queue full, memory stage must hold
//   dmem_rvalid_i, dmem_rdata_i       in-order load responses
//   regfile_*_o                       combinational register-file write
//   wbu_*_o                           registered trace of last retirement
//   wbu_stall_i                       downstream hold of the queue head
//   wbu_rsp_err_o                     sticky: response with no pending load
// Build option: WBU_RSP_BYPASS_EN lets a head load retire in the same
// cycle its response arrives.
`ifndef PC_INIT
`define PC_INIT 32'h0000_0000
`endif

module wbu_nb
  import cpu_core_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter int              DEPTH   = 4,
  parameter logic [XLEN-1:0] PC_INIT = XLEN'(`PC_INIT)
) (
  input  logic            clock_i,
  input  logic            nreset_i,
  input  logic            mem_valid_i,
  input  logic [XLEN-1:0] mem_pc_i,
  input  logic [31:0]     mem_instruct_i,
  input  logic [4:0]      mem_rdt_addr_i,
  input  logic [XLEN-1:0] mem_rdt_data_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            is_mem_op_i,
  input  logic            mem_op_type_i,
  output logic            mem_stall_o,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            regfile_w_enable_o,
  output logic [4:0]      regfile_rdt_addr_o,
  output logic [XLEN-1:0] regfile_rdt_data_o,
  output logic [XLEN-1:0] wbu_pc_o,
  output logic [31:0]     wbu_instruct_o,
  output logic [4:0]      wbu_rdt_addr_o,
  output logic [XLEN-1:0] wbu_rdt_data_o,
  output logic            wbu_bubble_o,
  input  logic            wbu_stall_i,
  output logic            wbu_rsp_err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(XLEN/8);

  wbu_entry_t       q [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head, tail, rsp_ptr;

  wbu_entry_t       new_entry;
  logic             push, pop, rsp_found, rsp_hit, bypass;
  logic [XLEN-1:0]  aligned, head_data;
  wbu_entry_t       head_e;

  assign mem_stall_o = (count == CNT_W'(DEPTH));
  assign push        = mem_valid_i & ~mem_stall_o;
  assign head_e      = q[head];

  always_comb begin
    new_entry          = '0;
    new_entry.pc       = WBU_XLEN_MAX'(mem_pc_i);
    new_entry.instruct = mem_instruct_i;
    new_entry.rd       = mem_rdt_addr_i;
    new_entry.data     = WBU_XLEN_MAX'(mem_rdt_data_i);
    new_entry.kind     = !is_mem_op_i ? ALU : (mem_op_type_i ? STORE : LOAD);
    new_entry.offset   = 3'(mem_addr_i[OFF_W-1:0]);
    new_entry.func3    = mem_instruct_i[14:12];
  end

  // Responses arrive in load-issue order, so the target is always the
  // oldest queued load still waiting; find it by scanning from the head.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rsp_ptr   = '0;
    rsp_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (!rsp_found && (CNT_W'(k) < count) &&
          (q[idx].kind == LOAD) && !rdy[idx]) begin
        rsp_ptr   = idx;
        rsp_found = 1'b1;
      end
    end
  end

  assign rsp_hit = dmem_rvalid_i & rsp_found;

  wbu_load_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .raw_i    (dmem_rdata_i),
    .offset_i (q[rsp_ptr].offset[OFF_W-1:0]),
    .func3_i  (q[rsp_ptr].func3),
    .data_o   (aligned)
  );

`ifdef WBU_RSP_BYPASS_EN
  assign bypass = rsp_hit & (rsp_ptr == head) & ~rdy[head];
`else
  assign bypass = 1'b0;
`endif

  assign pop       = (count != '0) & (rdy[head] | bypass) & ~wbu_stall_i;
  assign head_data = bypass ? aligned : head_e.data[XLEN-1:0];

  always_comb begin
    regfile_w_enable_o = 1'b0;
    regfile_rdt_addr_o = '0;
    regfile_rdt_data_o = '0;
    if (pop) begin
      regfile_w_enable_o = (head_e.kind != STORE) && (head_e.rd != 5'd0);
      regfile_rdt_addr_o = head_e.rd;
      regfile_rdt_data_o = head_data;
    end
  end

  // Queue control and trace registers.
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      count          <= '0;
      head           <= '0;
      tail           <= '0;
      rdy            <= '0;
      wbu_pc_o       <= PC_INIT;
      wbu_instruct_o <= NOP_INSTRUCT;
      wbu_rdt_addr_o <= '0;
      wbu_rdt_data_o <= '0;
      wbu_bubble_o   <= 1'b1;
      wbu_rsp_err_o  <= 1'b0;
    end else begin
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        rdy[tail] <= (new_entry.kind != LOAD);
        tail      <= tail + 1'b1;
      end
      // rsp_ptr is an occupied slot, tail an empty one: never the same.
      if (rsp_hit)
        rdy[rsp_ptr] <= 1'b1;
      if (dmem_rvalid_i && !rsp_found)
        wbu_rsp_err_o <= 1'b1;
      if (pop) begin
        head           <= head + 1'b1;
        wbu_pc_o       <= head_e.pc[XLEN-1:0];
        wbu_instruct_o <= head_e.instruct;
        wbu_rdt_addr_o <= head_e.rd;
        wbu_rdt_data_o <= head_data;
      end
      wbu_bubble_o <= ~pop;
    end
  end

  // Queue payload: data only, no reset needed.
  always_ff @(posedge clock_i) begin
    if (push)
      q[tail] <= new_entry;
    if (rsp_hit)
      q[rsp_ptr].data <= WBU_XLEN_MAX'(aligned);
  end

endmodule

// File: tb/tb_wbu_nb.sv
module tb_wbu_nb;
  import cpu_core_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] PCI   = 32'h0000_1000;
`ifdef WBU_RSP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock_i = 1'b0;
  logic            nreset_i = 1'b0;
  logic            mem_valid_i = 1'b0;
  logic [XLEN-1:0] mem_pc_i = '0;
  logic [31:0]     mem_instruct_i = '0;
  logic [4:0]      mem_rdt_addr_i = '0;
  logic [XLEN-1:0] mem_rdt_data_i = '0;
  logic [XLEN-1:0] mem_addr_i = '0;
  logic            is_mem_op_i = 1'b0;
  logic            mem_op_type_i = 1'b0;
  logic            mem_stall_o;
  logic            dmem_rvalid_i = 1'b0;
  logic [XLEN-1:0] dmem_rdata_i = '0;
  logic            regfile_w_enable_o;
  logic [4:0]      regfile_rdt_addr_o;
  logic [XLEN-1:0] regfile_rdt_data_o;
  logic [XLEN-1:0] wbu_pc_o;
  logic [31:0]     wbu_instruct_o;
  logic [4:0]      wbu_rdt_addr_o;
  logic [XLEN-1:0] wbu_rdt_data_o;
  logic            wbu_bubble_o;
  logic            wbu_stall_i = 1'b0;
  logic            wbu_rsp_err_o;

  wbu_nb #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_INIT(PCI)) dut (
    .clock_i(clock_i), .nreset_i(nreset_i),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_instruct_i(mem_instruct_i), .mem_rdt_addr_i(mem_rdt_addr_i),
    .mem_rdt_data_i(mem_rdt_data_i), .mem_addr_i(mem_addr_i),
    .is_mem_op_i(is_mem_op_i), .mem_op_type_i(mem_op_type_i),
    .mem_stall_o(mem_stall_o), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .regfile_w_enable_o(regfile_w_enable_o),
    .regfile_rdt_addr_o(regfile_rdt_addr_o),
    .regfile_rdt_data_o(regfile_rdt_data_o), .wbu_pc_o(wbu_pc_o),
    .wbu_instruct_o(wbu_instruct_o), .wbu_rdt_addr_o(wbu_rdt_addr_o),
    .wbu_rdt_data_o(wbu_rdt_data_o), .wbu_bubble_o(wbu_bubble_o),
    .wbu_stall_i(wbu_stall_i), .wbu_rsp_err_o(wbu_rsp_err_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every register-file write must be the oldest outstanding expectation.
  always @(negedge clock_i) begin
    if (nreset_i && regfile_w_enable_o === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_write", {59'd0, regfile_rdt_addr_o}, 64'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {59'd0, regfile_rdt_addr_o}, {59'd0, e.rd});
        chk("wr_data", {32'd0, regfile_rdt_data_o}, {32'd0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd,
                      input logic [31:0] data, input bit is_mem,
                      input bit is_store, input logic [2:0] f3,
                      input logic [31:0] addr);
    mem_valid_i    = 1'b1;
    mem_pc_i       = pc;
    mem_instruct_i = {17'd0, f3, rd, (is_mem ? 7'b0000011 : 7'b0010011)};
    mem_rdt_addr_i = rd;
    mem_rdt_data_i = data;
    mem_addr_i     = addr;
    is_mem_op_i    = is_mem;
    mem_op_type_i  = is_store;
    step();
    mem_valid_i    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_pc", 64'(wbu_pc_o), 64'(PCI));
    chk("rst_instr", 64'(wbu_instruct_o), 64'h13);
    chk("rst_rd", 64'(wbu_rdt_addr_o), 64'd0);
    chk("rst_data", 64'(wbu_rdt_data_o), 64'd0);
    chk("rst_bubble", 64'(wbu_bubble_o), 64'd1);
    chk("rst_err", 64'(wbu_rsp_err_o), 64'd0);
    chk("rst_stall", 64'(mem_stall_o), 64'd0);
    chk("rst_wen", 64'(regfile_w_enable_o), 64'd0);
    nreset_i = 1'b1;
    step();

    // ALU op: write one cycle after push, trace next edge
    sb.push_back('{rd: 5'd5, data: 32'h1234});
    push(32'h100, 5'd5, 32'h1234, 0, 0, 3'b000, 0);
    chk("alu_wen", 64'(regfile_w_enable_o), 64'd1);
    step();
    chk("alu_tr_pc", 64'(wbu_pc_o), 64'h100);
    chk("alu_tr_instr", 64'(wbu_instruct_o), 64'h0000_0293);
    chk("alu_tr_rd", 64'(wbu_rdt_addr_o), 64'd5);
    chk("alu_tr_data", 64'(wbu_rdt_data_o), 64'h1234);
    chk("alu_bubble0", 64'(wbu_bubble_o), 64'd0);
    step();
    chk("alu_bubble1", 64'(wbu_bubble_o), 64'd1);

    // rd=0 ALU op retires without a write
    push(32'h104, 5'd0, 32'hdead, 0, 0, 3'b000, 0);
    chk("x0_wen", 64'(regfile_w_enable_o), 64'd0);
    step();
    chk("x0_bubble", 64'(wbu_bubble_o), 64'd0);
    chk("x0_tr_pc", 64'(wbu_pc_o), 64'h104);

    // Store retires, no write
    push(32'h108, 5'd3, 32'h0, 1, 1, 3'b010, 0);
    chk("st_wen", 64'(regfile_w_enable_o), 64'd0);
    step();
    chk("st_tr_pc", 64'(wbu_pc_o), 64'h108);

    // LB offset 3, response latency with load at head
    push(32'h10c, 5'd6, 32'h0, 1, 0, F3_LB, 32'h3);
    step(); step();
    sb.push_back('{rd: 5'd6, data: 32'hFFFF_FF80});
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_FF00;
    #1;
    chk("lb_same_cycle_wen", 64'(regfile_w_enable_o), 64'(BYP));
    step();
    dmem_rvalid_i = 1'b0;
    chk("lb_next_cycle_wen", 64'(regfile_w_enable_o), 64'(!BYP));
    drain();

    // LHU offset 2
    push(32'h110, 5'd7, 32'h0, 1, 0, F3_LHU, 32'h2);
    sb.push_back('{rd: 5'd7, data: 32'h0000_BEEF});
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
    step();
    dmem_rvalid_i = 1'b0;
    drain();

    // Fill the queue with loads, then respond back to back
    push(32'h200, 5'd10, 0, 1, 0, F3_LW,  32'h0);
    push(32'h204, 5'd11, 0, 1, 0, F3_LH,  32'h2);
    push(32'h208, 5'd12, 0, 1, 0, F3_LBU, 32'h1);
    push(32'h20c, 5'd13, 0, 1, 0, F3_LW,  32'h0);
    chk("full_stall", 64'(mem_stall_o), 64'd1);
    chk("full_no_wen", 64'(regfile_w_enable_o), 64'd0);
    sb.push_back('{rd: 5'd10, data: 32'h1111_2222});
    sb.push_back('{rd: 5'd11, data: 32'hFFFF_8001});
    sb.push_back('{rd: 5'd12, data: 32'h0000_00AB});
    sb.push_back('{rd: 5'd13, data: 32'h7654_3210});
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h1111_2222; step();
    chk("stall_after_rsp0", 64'(mem_stall_o), 64'(!BYP));
    dmem_rdata_i = 32'h8001_0000; step();
    chk("stall_after_rsp1", 64'(mem_stall_o), 64'd0);
    dmem_rdata_i = 32'h0000_AB00; step();
    dmem_rdata_i = 32'h7654_3210; step();
    dmem_rvalid_i = 1'b0;
    drain();
    chk("drained_trace_pc", 64'(wbu_pc_o), 64'h20c);

    // ALU op behind a slow load must wait
    push(32'h300, 5'd14, 0, 1, 0, F3_LW, 32'h0);
    push(32'h304, 5'd15, 32'h5555, 0, 0, 3'b000, 0);
    sb.push_back('{rd: 5'd14, data: 32'hCAFE_F00D});
    sb.push_back('{rd: 5'd15, data: 32'h5555});
    for (int i = 0; i < 5; i++) begin
      chk("wait_no_wen", 64'(regfile_w_enable_o), 64'd0);
      step();
    end
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    step();
    dmem_rvalid_i = 1'b0;
    drain();
    chk("order_tr_rd", 64'(wbu_rdt_addr_o), 64'd15);

    // Downstream hold on a ready head
    wbu_stall_i = 1'b1;
    push(32'h400, 5'd9, 32'h9999, 0, 0, 3'b000, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_wen", 64'(regfile_w_enable_o), 64'd0);
      step();
      chk("hold_bubble", 64'(wbu_bubble_o), 64'd1);
    end
    sb.push_back('{rd: 5'd9, data: 32'h9999});
    wbu_stall_i = 1'b0;
    #1;
    chk("release_wen", 64'(regfile_w_enable_o), 64'd1);
    step();
    chk("release_tr_pc", 64'(wbu_pc_o), 64'h400);
    drain();

    // Response with nothing pending: sticky error
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1;
    step();
    dmem_rvalid_i = 1'b0;
    chk("err_set", 64'(wbu_rsp_err_o), 64'd1);
    step(); step(); step();
    chk("err_sticky", 64'(wbu_rsp_err_o), 64'd1);
    chk("err_no_wen", 64'(regfile_w_enable_o), 64'd0);

    // Reset mid-operation clears queue and error
    push(32'h500, 5'd20, 0, 1, 0, F3_LW, 32'h0);
    nreset_i = 1'b0;
    #1;
    chk("midrst_err", 64'(wbu_rsp_err_o), 64'd0);
    chk("midrst_pc", 64'(wbu_pc_o), 64'(PCI));
    step();
    nreset_i = 1'b1;
    push(32'h600, 5'd21, 32'h21, 0, 0, 3'b000, 0);
    sb.push_back('{rd: 5'd21, data: 32'h21});
    chk("postrst_wen", 64'(regfile_w_enable_o), 64'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
